// File: rtl/gullfaxi_port_arbiter.sv
// Gullfaxi port arbiter: shares one output link among NREQ router ports with
// packet-granular round-robin arbitration and one register stage of forwarding.
//
// Port handshake: a router raises R_req[i] (with R_length valid) and holds it
// for the whole packet. After its single-cycle R_grant[i] pulse it presents
// the first beat with R_start[i]. Every following cycle must carry a beat:
// either a data beat (R_req[i] high, no start/end) or the last beat (R_end[i]).
// A cycle with none of these while a packet is open closes it as a length error.
// Each accepted beat appears on L_* exactly one cycle later.
module gullfaxi_port_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 8,
  parameter int CNTW    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   R_req,
  input  logic [NREQ-1:0]   R_start,
  input  logic [NREQ*6-1:0] R_length,
  input  logic [NREQ*8-1:0] R_data,
  input  logic [NREQ-1:0]   R_end,
  output logic [NREQ-1:0]   R_grant,
  output logic              L_valid,
  output logic [7:0]        L_data,
  output logic              L_start,
  output logic              L_end,
  output logic [5:0]        L_length,
  output logic [2:0]        L_src,
  output logic              err_len,
  output logic              err_timeout,
  output logic [CNTW-1:0]   pkt_count,
  output logic [1:0]        dbg_state
);

  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_GRANT      = 2'd1,
    S_WAIT_START = 2'd2,
    S_XFER       = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   src_q, src_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [5:0]      len_q, len_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [6:0]      beat_q, beat_d;
  logic [CNTW-1:0] pkt_count_q, pkt_count_d;
  logic            err_len_q, err_len_d;
  logic            err_timeout_q, err_timeout_d;
  logic            l_valid_q, l_valid_d;
  logic [7:0]      l_data_q, l_data_d;
  logic            l_start_q, l_start_d;
  logic            l_end_q, l_end_d;
  logic [5:0]      l_length_q, l_length_d;
  logic [2:0]      l_src_q, l_src_d;

  logic [5:0]      len_arr [NREQ];
  logic [7:0]      dat_arr [NREQ];
  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   src_next;
  logic [6:0]      len_ext;
  logic [6:0]      beat_inc;
  logic            accept;
  logic            done;
  logic [6:0]      done_cnt;

  // Unpack the flat per-port length/data buses into arrays.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      len_arr[i] = R_length[i*6 +: 6];
      dat_arr[i] = R_data[i*8 +: 8];
    end
  end

  // Round-robin pick: first requesting index at or after the rr pointer.
  always_comb begin
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(rr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!pick_found && R_req[PW'(j)]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(j);
      end
    end
  end

  // Grant pulse is a pure decode of the GRANT state so reset clears it at once.
  always_comb begin
    R_grant = '0;
    if (state_q == S_GRANT && len_q != 6'd0) R_grant[src_q] = 1'b1;
  end

  // Next-state, counters, error pulses and forwarding register inputs.
  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    rr_d          = rr_q;
    len_d         = len_q;
    wait_d        = wait_q;
    beat_d        = beat_q;
    pkt_count_d   = pkt_count_q;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    accept        = 1'b0;
    done          = 1'b0;
    done_cnt      = beat_q;
    src_next      = (src_q == PW'(NREQ-1)) ? '0 : src_q + PW'(1);
    len_ext       = {1'b0, len_q};
    beat_inc      = (beat_q == 7'h7f) ? beat_q : beat_q + 7'd1;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          src_d   = pick_idx;
          len_d   = len_arr[pick_idx];
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        wait_d = '0;
        if (len_q == 6'd0) begin
          err_len_d = 1'b1;
          rr_d      = src_next;
          state_d   = S_IDLE;
        end else begin
          state_d = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (R_start[src_q]) begin
          accept = 1'b1;
          beat_d = 7'd1;
          if (R_end[src_q]) begin
            done     = 1'b1;
            done_cnt = 7'd1;
          end else begin
            state_d = S_XFER;
          end
        end else if (wait_q == WW'(TIMEOUT-1)) begin
          err_timeout_d = 1'b1;
          rr_d          = src_next;
          state_d       = S_IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_XFER: begin
        if (R_start[src_q]) begin
          // A restart closes the open packet; the new start beat is dropped.
          err_len_d = 1'b1;
          rr_d      = src_next;
          state_d   = S_IDLE;
        end else if (R_end[src_q]) begin
          accept   = 1'b1;
          beat_d   = beat_inc;
          done     = 1'b1;
          done_cnt = beat_inc;
        end else if (R_req[src_q]) begin
          accept = 1'b1;
          beat_d = beat_inc;
          // Flag the first beat past the declared length, keep forwarding.
          if (beat_inc == len_ext + 7'd1) err_len_d = 1'b1;
        end else begin
          err_len_d = 1'b1;
          rr_d      = src_next;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Completion: exact length counts the packet; short packets and an end
    // beat that is itself the first overflow beat flag an error. Longer
    // overruns were already flagged at their overflow beat.
    if (done) begin
      if (done_cnt == len_ext) pkt_count_d = pkt_count_q + CNTW'(1);
      else if (done_cnt < len_ext || done_cnt == len_ext + 7'd1) err_len_d = 1'b1;
      rr_d    = src_next;
      state_d = S_IDLE;
    end

    l_valid_d  = accept;
    l_data_d   = accept ? dat_arr[src_q] : 8'd0;
    l_start_d  = accept & R_start[src_q];
    l_end_d    = accept & R_end[src_q];
    l_length_d = accept ? len_q : 6'd0;
    l_src_d    = accept ? 3'(src_q) : 3'd0;
  end

  // State and output registers; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      src_q         <= '0;
      rr_q          <= '0;
      len_q         <= '0;
      wait_q        <= '0;
      beat_q        <= '0;
      pkt_count_q   <= '0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      l_valid_q     <= 1'b0;
      l_data_q      <= '0;
      l_start_q     <= 1'b0;
      l_end_q       <= 1'b0;
      l_length_q    <= '0;
      l_src_q       <= '0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      rr_q          <= rr_d;
      len_q         <= len_d;
      wait_q        <= wait_d;
      beat_q        <= beat_d;
      pkt_count_q   <= pkt_count_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      l_valid_q     <= l_valid_d;
      l_data_q      <= l_data_d;
      l_start_q     <= l_start_d;
      l_end_q       <= l_end_d;
      l_length_q    <= l_length_d;
      l_src_q       <= l_src_d;
    end
  end

  assign L_valid     = l_valid_q;
  assign L_data      = l_data_q;
  assign L_start     = l_start_q;
  assign L_end       = l_end_q;
  assign L_length    = l_length_q;
  assign L_src       = l_src_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign pkt_count   = pkt_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_gullfaxi_port_arbiter.sv
// Directed bench for gullfaxi_port_arbiter: drives router-port packets and
// scoreboards the forwarded link beats plus grants, error pulses and counts.
module tb_gullfaxi_port_arbiter;

  localparam int NREQ = 3;

  logic        clk;
  logic        reset;
  logic [2:0]  R_req;
  logic [2:0]  R_start;
  logic [17:0] R_length;
  logic [23:0] R_data;
  logic [2:0]  R_end;
  logic [2:0]  R_grant;
  logic        L_valid;
  logic [7:0]  L_data;
  logic        L_start;
  logic        L_end;
  logic [5:0]  L_length;
  logic [2:0]  L_src;
  logic        err_len;
  logic        err_timeout;
  logic [15:0] pkt_count;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int err_len_cnt = 0;
  int err_to_cnt = 0;

  // {start, end, src[2:0], length[5:0], data[7:0]}
  logic [18:0] exp_q[$];

  gullfaxi_port_arbiter #(.NREQ(NREQ), .TIMEOUT(8), .CNTW(16)) dut (
    .clk(clk), .reset(reset),
    .R_req(R_req), .R_start(R_start), .R_length(R_length), .R_data(R_data),
    .R_end(R_end), .R_grant(R_grant),
    .L_valid(L_valid), .L_data(L_data), .L_start(L_start), .L_end(L_end),
    .L_length(L_length), .L_src(L_src),
    .err_len(err_len), .err_timeout(err_timeout),
    .pkt_count(pkt_count), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every link beat is popped against the queue; idle link is all-zero.
  always @(negedge clk) begin
    logic [18:0] exp_beat;
    if (err_len === 1'b1) err_len_cnt++;
    if (err_timeout === 1'b1) err_to_cnt++;
    if (L_valid === 1'b1) begin
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_beat = exp_q.pop_front();
        check("l_beat", {13'd0, L_start, L_end, L_src, L_length, L_data}, {13'd0, exp_beat});
      end
    end else begin
      check("l_idle_zero", {13'd0, L_start, L_end, L_src, L_length, L_data}, 32'd0);
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  task automatic wait_grant(input int p);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (R_grant !== 3'b000) break;
    end
    check($sformatf("grant_port%0d", p), {29'd0, R_grant}, 32'(1 << p));
  endtask

  task automatic drive_beat(input int p, input bit s, input bit e, input logic [5:0] len, input bit push);
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    R_start[p] = s;
    R_end[p] = e;
    R_data[p*8 +: 8] = d;
    if (push) exp_q.push_back({s, e, 3'(p), len, d});
    step();
    R_start[p] = 1'b0;
    R_end[p] = 1'b0;
  endtask

  task automatic send_packet(input int p, input logic [5:0] len, input int nbeats,
                             input int delay, input bit keep_req);
    R_req[p] = 1'b1;
    R_length[p*6 +: 6] = len;
    wait_grant(p);
    repeat (delay) step();
    for (int b = 0; b < nbeats; b++)
      drive_beat(p, b == 0, b == nbeats - 1, len, 1'b1);
    if (!keep_req) R_req[p] = 1'b0;
  endtask

  // Directed stimulus
  initial begin
    int n;
    reset = 1'b0;
    R_req = '0; R_start = '0; R_end = '0; R_length = '0; R_data = '0;
    repeat (3) step();
    check("rst_outputs", {9'd0, R_grant, L_valid, L_data, L_start, L_end, L_length, L_src,
                          err_len, err_timeout}, 32'd0);
    check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b1;
    step();

    // 1: port1, length 4, start two cycles after grant
    send_packet(1, 6'd4, 4, 2, 1'b0);
    repeat (2) step();
    check("t1_pkt_count", {16'd0, pkt_count}, 32'd1);
    check("t1_drained", exp_q.size(), 32'd0);
    check("t1_no_err", err_len_cnt + err_to_cnt, 32'd0);

    // 2: all ports requesting continuously, length 2 each, from rr=0
    do_reset();
    check("t2_rst_pkt_count", {16'd0, pkt_count}, 32'd0);
    R_length = {6'd2, 6'd2, 6'd2};
    R_req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_grant(k % 3);
      repeat (2) step();
      drive_beat(k % 3, 1'b1, 1'b0, 6'd2, 1'b1);
      drive_beat(k % 3, 1'b0, 1'b1, 6'd2, 1'b1);
    end
    R_req = 3'b000;
    repeat (2) step();
    check("t2_pkt_count", {16'd0, pkt_count}, 32'd6);
    check("t2_drained", exp_q.size(), 32'd0);
    check("t2_no_err", err_len_cnt + err_to_cnt, 32'd0);

    // 3: port2 single-beat packet of length 1
    send_packet(2, 6'd1, 1, 1, 1'b0);
    repeat (2) step();
    check("t3_pkt_count", {16'd0, pkt_count}, 32'd7);
    check("t3_no_err", err_len_cnt + err_to_cnt, 32'd0);

    // 4: port0 declares 5 beats but ends after 3
    send_packet(0, 6'd5, 3, 2, 1'b0);
    @(negedge clk);
    check("t4_err_len_pulse", {31'd0, err_len}, 32'd1);
    step();
    step();
    check("t4_err_len_count", err_len_cnt, 32'd1);
    check("t4_pkt_count", {16'd0, pkt_count}, 32'd7);

    // rr must now be 1: ports 0 and 1 both request, port1 wins
    R_req[0] = 1'b1;
    R_length[5:0] = 6'd3;
    send_packet(1, 6'd2, 2, 2, 1'b0);

    // 5: port0 granted next but never starts
    wait_grant(0);
    R_req[1] = 1'b1;
    R_length[11:6] = 6'd2;
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (err_timeout === 1'b1) break;
    end
    check("t5_timeout_latency", n, 32'd9);
    R_req[0] = 1'b0;
    send_packet(1, 6'd2, 2, 3, 1'b0);
    repeat (2) step();
    check("t5_timeout_count", err_to_cnt, 32'd1);
    check("t5_pkt_count", {16'd0, pkt_count}, 32'd9);
    check("t5_err_len_count", err_len_cnt, 32'd1);

    // 6: reset during beat 3 of a length-10 packet
    R_req[0] = 1'b1;
    R_length[5:0] = 6'd10;
    wait_grant(0);
    repeat (2) step();
    drive_beat(0, 1'b1, 1'b0, 6'd10, 1'b1);
    drive_beat(0, 1'b0, 1'b0, 6'd10, 1'b0);
    R_data[7:0] = 8'($urandom_range(0, 255));
    #1 reset = 1'b0;
    #1;
    check("t6_async_outputs", {9'd0, R_grant, L_valid, L_data, L_start, L_end, L_length, L_src,
                               err_len, err_timeout}, 32'd0);
    check("t6_async_pkt_count", {16'd0, pkt_count}, 32'd0);
    check("t6_async_state", {30'd0, dbg_state}, 32'd0);
    step();
    reset = 1'b1;
    R_req[0] = 1'b0;
    for (int b = 0; b < 7; b++) drive_beat(0, 1'b0, b == 6, 6'd10, 1'b0);
    check("t6_idle_after_reset", {30'd0, dbg_state}, 32'd0);
    check("t6_drained", exp_q.size(), 32'd0);
    send_packet(2, 6'd3, 3, 2, 1'b0);
    repeat (2) step();
    check("t6_pkt_count", {16'd0, pkt_count}, 32'd1);
    check("t6_final_drained", exp_q.size(), 32'd0);
    check("t6_err_totals", err_len_cnt + err_to_cnt, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
